// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: instruction-fetch FSM states and the default reset PC.
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } if_state_t;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0060;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register with its next-PC mux: redirect target, sequential pc+4, or hold.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // Redirect wins over sequential advance; targets are forced word-aligned.
  always_comb begin
    pc_next = pc;
    if (redirect_valid)
      pc_next = {redirect_pc[31:2], 2'b00};
    else if (advance)
      pc_next = pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch stage: FETCH/HOLD/DROP handshake with imem and IF/ID register.
// Optional performance counters enabled by defining IF_PERF_CNT_EN.
module if_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_inst_out,
  output logic [31:0] IF_pc_out,
  output logic        IF_valid_out,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_flush_count
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic        advance;

  assign advance      = (state == FETCH) && imem_resp && !redirect_valid;
  assign imem_read    = (state != HOLD);
  // In DROP the pc already holds the redirect target; keep presenting the in-flight address.
  assign imem_address = (state == DROP) ? drop_addr : pc;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .pc             (pc)
  );

  always_ff @(posedge clk) begin
    if (state == FETCH && redirect_valid && !imem_resp)
      drop_addr <= pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= FETCH;
      IF_inst_out  <= '0;
      IF_pc_out    <= '0;
      IF_valid_out <= 1'b0;
      hold_inst    <= '0;
      hold_pc      <= '0;
    end else if (redirect_valid) begin
      IF_valid_out <= 1'b0;
      hold_inst    <= '0;
      hold_pc      <= '0;
      case (state)
        FETCH:   state <= imem_resp ? FETCH : DROP;
        HOLD:    state <= FETCH;
        DROP:    state <= imem_resp ? FETCH : DROP;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_resp) begin
            if (stall) begin
              hold_inst <= imem_rdata;
              hold_pc   <= pc;
              state     <= HOLD;
            end else begin
              IF_inst_out  <= imem_rdata;
              IF_pc_out    <= pc;
              IF_valid_out <= 1'b1;
            end
          end else if (!stall) begin
            IF_valid_out <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            IF_inst_out  <= hold_inst;
            IF_pc_out    <= hold_pc;
            IF_valid_out <= 1'b1;
            state        <= FETCH;
          end
        end
        DROP: begin
          if (imem_resp)
            state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic deliver;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  assign deliver = !redirect_valid && !stall &&
                   ((state == FETCH && imem_resp) || state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (deliver)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_count = fetch_cnt;
  assign perf_flush_count = flush_cnt;
`else
  assign perf_fetch_count = '0;
  assign perf_flush_count = '0;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000060, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset: synchronous, active-low.
REQ-004 SHALL have port redirect_valid, input, 1, meaning taken branch/jump resolved in EX (EX true_branch).
REQ-005 SHALL have port redirect_pc, input, 32, meaning the target from EX (EX branch_pc).
REQ-006 SHALL have port stall, input, 1, meaning the hazard unit requests that the IF/ID outputs hold.
REQ-007 SHALL have port imem_read, output, 1, meaning the instruction memory read request.
REQ-008 SHALL have port imem_address, output, 32, meaning the fetch address.
REQ-009 SHALL have port imem_resp, input, 1, meaning imem_rdata is valid this cycle.
REQ-010 SHALL have port imem_rdata, input, 32, meaning the fetched instruction word.
REQ-011 SHALL have port IF_inst_out, output, 32, meaning the registered instruction to ID.
REQ-012 SHALL have port IF_pc_out, output, 32, meaning the registered PC of IF_inst_out.
REQ-013 SHALL have port IF_valid_out, output, 1, meaning IF_inst_out is a real instruction, not a bubble.
REQ-014 SHALL have ports perf_fetch_count and perf_flush_count, output, 32 each, meaning performance counters (REQ-030).

Function
REQ-015 SHALL implement FSM states FETCH (request outstanding), HOLD (word buffered, downstream stalled) and DROP (outstanding request to be discarded).
REQ-016 SHALL assert imem_read in FETCH and DROP, and deassert it in HOLD.
REQ-017 SHALL hold imem_address constant from the first request cycle until the imem_resp cycle, including in DROP, where it keeps the pre-redirect address.
REQ-018 In FETCH with imem_resp=1, stall=0 and redirect_valid=0, SHALL load {imem_rdata, pc} into the outputs with IF_valid_out=1, set pc<=pc+4 (mod 2^32), and remain in FETCH; this gives one cycle of latency from response to output.
REQ-019 In FETCH with imem_resp=1, stall=1 and redirect_valid=0, SHALL capture imem_rdata into the hold buffer, set pc<=pc+4, go to HOLD and leave the outputs unchanged.
REQ-020 In HOLD with stall=0, SHALL move the buffer to the outputs with IF_valid_out=1 and go to FETCH.
REQ-021 In FETCH with imem_resp=0 and stall=0, SHALL drive IF_valid_out<=0 (bubble).
REQ-022 Whenever stall=1 and redirect_valid=0, SHALL hold IF_inst_out, IF_pc_out and IF_valid_out unchanged.
REQ-023 redirect_valid=1 SHALL take priority over stall and imem_resp: set pc<=redirect_pc with bits [1:0] forced to 0, set IF_valid_out<=0, and discard the buffer.
REQ-024 On a redirect in FETCH with imem_resp=0, SHALL go to DROP; with imem_resp=1 in the same cycle, SHALL discard the word and stay in FETCH.
REQ-025 On a redirect in HOLD, SHALL go to FETCH; on a redirect in DROP, SHALL update pc and stay in DROP.
REQ-026 In DROP with imem_resp=1, SHALL discard imem_rdata, leave the outputs unchanged except per REQ-023, and go to FETCH.
REQ-027 SHALL never present to ID an instruction fetched from a pre-redirect address after the redirect cycle.

Reset
REQ-028 While rst=0 at a clock edge, SHALL set state=FETCH, pc=RESET_PC, IF_inst_out=0, IF_pc_out=0, IF_valid_out=0, hold buffer=0 and both counters=0.
REQ-029 Reset during DROP or HOLD SHALL abandon the pending transfer; a stale imem_resp arriving after reset SHALL be accepted as the RESET_PC response.

Configuration
REQ-030 With IF_PERF_CNT_EN defined, SHALL increment perf_fetch_count on each instruction reaching the outputs with valid=1, and perf_flush_count on each redirect_valid cycle; counters SHALL wrap at 2^32. Without the macro, both SHALL be tied to 0 with no counter registers.

Structure
REQ-031 The if_state_t enum (FETCH, HOLD, DROP) and the RESET_PC default constant SHALL live in the shared rv32i_types package.
REQ-032 The PC register with its next-PC mux (pc+4 / redirect / hold) SHALL be a single sub-module named pc_reg; all other logic SHALL stay in if_stage.

Verification
REQ-033 Reset, then zero-wait memory returning 32'h00000013 -> imem_address sequence 0x60, 0x64, 0x68; IF_valid_out=1 one cycle after each resp, with IF_pc_out matching.
REQ-034 Response at 0x64 with stall=1 for 3 cycles -> outputs hold the 0x60 instruction, imem_read=0 while in HOLD, and the 0x64 word appears the cycle after stall drops.
REQ-035 redirect_valid=1 with redirect_pc=0x200 while the 0x68 request is outstanding -> imem_address stays 0x68 until resp, that word is dropped, the next request is 0x200, and IF_valid_out=0 meanwhile.
REQ-036 Simultaneous redirect_valid=1 (0x300), stall=1 and imem_resp=1 -> word discarded, IF_valid_out=0 next cycle, next address 0x300.
REQ-037 redirect_pc=0x00000403 -> next imem_address 0x400.
REQ-038 With IF_PERF_CNT_EN: 5 delivered instructions and 2 redirects -> perf_fetch_count=5 and perf_flush_count=2; without the macro both read 0.
